// File: rtl/cpu_pkg.sv
// Shared core definitions: PC-stage state encoding, data width and
// default reset/trap vectors. Imported by the pc_unit slice.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // PC-stage sequencing states. ST_TRAP is only reachable when the
  // misaligned-target trap is built in.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_TRAP = 2'd3
  } state_t;

endpackage

// File: rtl/pc_unit_if.sv
// Bundle between the PC stage and its neighbours: branch decision and
// operands in, fetch address/request and trap report out.
//
// Handshake: pc_unit raises imem_req while it wants the instruction at
// pc; imem_ready=1 in a cycle means memory holds valid data for that pc.
// The instruction commits on an edge where the stage is in RUN with
// imem_ready=1 and stall=0; only then do branch_taken/is_jalr/rs1/imm
// take effect.
interface pc_unit_if;
  import cpu_pkg::*;

  logic            branch_taken;
  logic            is_jalr;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] imm;
  logic            stall;
  logic            imem_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            imem_req;
  logic            trap;
  logic [XLEN-1:0] trap_addr;
  state_t          dbg_state;

  // The PC stage drives the fetch address and request.
  modport master (
    input  branch_taken, is_jalr, rs1, imm, stall, imem_ready,
    output pc, pc_plus4, imem_req, trap, trap_addr, dbg_state
  );

  // Branch unit / memory / core side.
  modport slave (
    output branch_taken, is_jalr, rs1, imm, stall, imem_ready,
    input  pc, pc_plus4, imem_req, trap, trap_addr, dbg_state
  );

endinterface

// File: rtl/pc_unit_next_pc_calc.sv
// Combinational next-PC target mux: sequential pc+4, pc-relative
// branch/jal, or register-relative jalr with bit0 cleared.
// All adds wrap modulo 2^32.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            branch_taken,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc_plus4
);

  logic [XLEN-1:0] jalr_sum;

  assign pc_plus4 = pc + 32'd4;
  assign jalr_sum = rs1 + imm;

  // Pick the target; jalr drops bit0 of the computed address.
  always_comb begin
    target = pc_plus4;
    if (branch_taken) begin
      if (is_jalr) target = {jalr_sum[XLEN-1:1], 1'b0};
      else         target = pc + imm;
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: holds pc, sequences BOOT/RUN/WAIT(/TRAP) and
// drives the instruction fetch request.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- when defined, a committed
// redirect whose target has bits [1:0] != 0 jumps to TRAP_VECTOR and
// reports the faulting address; when undefined, targets are forced to
// word alignment and trap/trap_addr stay 0.
module pc_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic       clk,
  input  logic       rst,
  pc_unit_if.master  bus
);

  state_t          state_q;
  state_t          state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] trap_addr_q;
  logic [XLEN-1:0] raw_next;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] pc_plus4;
  logic            commit;
  logic            take_trap;
  logic            imem_req;

  next_pc_calc u_next_pc_calc (
    .pc           (pc_q),
    .rs1          (bus.rs1),
    .imm          (bus.imm),
    .branch_taken (bus.branch_taken),
    .is_jalr      (bus.is_jalr),
    .target       (raw_next),
    .pc_plus4     (pc_plus4)
  );

  // An instruction retires only with valid fetch data and no core hold.
  assign commit = (state_q == ST_RUN) && bus.imem_ready && !bus.stall;

`ifdef PC_MISALIGN_TRAP_EN
  assign next_pc   = raw_next;
  // pc+4 from an aligned pc is always aligned, so only redirects can trap.
  assign take_trap = commit && bus.branch_taken && (raw_next[1:0] != 2'b00);
`else
  assign next_pc   = raw_next & ~32'h3;
  assign take_trap = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_BOOT;
    else     state_q <= state_d;
  end

  // Next-state and fetch-request decode.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        imem_req = 1'b1;
        if (!bus.imem_ready) state_d = ST_WAIT;
        else if (take_trap)  state_d = ST_TRAP;
      end
      ST_WAIT: begin
        imem_req = 1'b1;
        if (bus.imem_ready) state_d = ST_RUN;
      end
      ST_TRAP: state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
  end

  // PC register: trap vector wins over the computed target.
  always_ff @(posedge clk) begin
    if (rst)            pc_q <= RESET_VECTOR;
    else if (take_trap) pc_q <= TRAP_VECTOR;
    else if (commit)    pc_q <= next_pc;
  end

  // Faulting target, kept until the next trap or reset.
  always_ff @(posedge clk) begin
    if (rst)            trap_addr_q <= '0;
    else if (take_trap) trap_addr_q <= next_pc;
  end

  assign bus.pc        = pc_q;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.imem_req  = imem_req;
  assign bus.trap      = (state_q == ST_TRAP);
  assign bus.trap_addr = trap_addr_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_pc_unit.sv
// Table-driven bench for pc_unit. Each row drives one cycle of inputs and
// lists the outputs expected after that edge; expectations go through a
// scoreboard queue and are compared #1 after the edge.
// Expectations follow PC_MISALIGN_TRAP_EN when it is defined.
module tb_pc_unit;
  import cpu_pkg::*;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int W = 3 * 32 + 4;

  typedef struct {
    string       name;
    logic        rst;
    logic        bt;
    logic        jalr;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic        stall;
    logic        rdy;
    logic [31:0] exp_pc;
    logic        exp_req;
    logic        exp_trap;
    logic [31:0] exp_taddr;
    logic [1:0]  exp_st;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if bus();

  pc_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  vec_t         vecs[$];
  int           n_cmp = 0;
  int           n_err = 0;

  task automatic check(input string vname, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", vname, field, act, exp);
    end
  endtask

  task automatic add(input string name, input logic r, input logic bt,
                     input logic jalr, input logic [31:0] rs1,
                     input logic [31:0] imm, input logic stall,
                     input logic rdy, input logic [31:0] epc,
                     input logic ereq, input logic etrap,
                     input logic [31:0] etaddr, input logic [1:0] est);
    vec_t v;
    v.name = name; v.rst = r; v.bt = bt; v.jalr = jalr; v.rs1 = rs1;
    v.imm = imm; v.stall = stall; v.rdy = rdy; v.exp_pc = epc;
    v.exp_req = ereq; v.exp_trap = etrap; v.exp_taddr = etaddr;
    v.exp_st = est;
    vecs.push_back(v);
  endtask

  // driver: one cycle of stimulus with its expectation queued
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst              = v.rst;
    bus.branch_taken = v.bt;
    bus.is_jalr      = v.jalr;
    bus.rs1          = v.rs1;
    bus.imm          = v.imm;
    bus.stall        = v.stall;
    bus.imem_ready   = v.rdy;
    exp_q.push_back({v.exp_pc, v.exp_pc + 32'd4, v.exp_taddr,
                     v.exp_req, v.exp_trap, v.exp_st});
    name_q.push_back(v.name);
  endtask

  // monitor side: pop one expectation and compare all outputs
  task automatic compare_one();
    logic [W-1:0] e;
    string        nm;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    check(nm, "pc",        bus.pc,               e[99:68]);
    check(nm, "pc_plus4",  bus.pc_plus4,         e[67:36]);
    check(nm, "trap_addr", bus.trap_addr,        e[35:4]);
    check(nm, "imem_req",  {31'd0, bus.imem_req}, {31'd0, e[3]});
    check(nm, "trap",      {31'd0, bus.trap},     {31'd0, e[2]});
    check(nm, "state",     {30'd0, bus.dbg_state}, {30'd0, e[1:0]});
  endtask

  initial begin
    logic [31:0] mis_pc;
    logic [31:0] mis_ta;
    bus.branch_taken = 1'b0;
    bus.is_jalr      = 1'b0;
    bus.rs1          = '0;
    bus.imm          = '0;
    bus.stall        = 1'b0;
    bus.imem_ready   = 1'b1;

    //   name        rst bt jl rs1          imm           st rdy exp_pc        req trp taddr  st
    add("reset0",    1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        0, 0, 32'h0, 2'd0);
    add("reset1",    1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        0, 0, 32'h0, 2'd0);
    add("boot",      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        1, 0, 32'h0, 2'd1);
    add("seq4",      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h4,        1, 0, 32'h0, 2'd1);
    add("seq8",      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h8,        1, 0, 32'h0, 2'd1);
    add("seqc",      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'hC,        1, 0, 32'h0, 2'd1);
    add("br_fwd",    0, 1, 0, 32'h0,       32'h14,       0, 1, 32'h20,       1, 0, 32'h0, 2'd1);
    add("br_back",   0, 1, 0, 32'h0,       32'hFFFF_FFF0,0, 1, 32'h10,       1, 0, 32'h0, 2'd1);
    add("jalr",      0, 1, 1, 32'h1001,    32'h4,        0, 1, 32'h1004,     1, 0, 32'h0, 2'd1);
    add("br_to40",   0, 1, 0, 32'h0,       32'hFFFF_F03C,0, 1, 32'h40,       1, 0, 32'h0, 2'd1);
    add("wait1",     0, 1, 0, 32'h0,       32'h80,       0, 0, 32'h40,       1, 0, 32'h0, 2'd2);
    add("wait2",     0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h40,       1, 0, 32'h0, 2'd2);
    add("wait3",     0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h40,       1, 0, 32'h0, 2'd2);
    add("wait_exit", 0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h40,       1, 0, 32'h0, 2'd1);
    add("post_wait", 0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h44,       1, 0, 32'h0, 2'd1);
    add("stall_br",  0, 1, 0, 32'h0,       32'h100,      1, 1, 32'h44,       1, 0, 32'h0, 2'd1);
    add("post_stall",0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h48,       1, 0, 32'h0, 2'd1);
    add("stall_nrdy",0, 0, 0, 32'h0,       32'h0,        1, 0, 32'h48,       1, 0, 32'h0, 2'd2);
    add("wait_br",   0, 1, 0, 32'h0,       32'h200,      0, 1, 32'h48,       1, 0, 32'h0, 2'd1);
    add("br_top",    0, 1, 0, 32'h0,       32'hFFFF_FFB4,0, 1, 32'hFFFF_FFFC,1, 0, 32'h0, 2'd1);
    add("wrap",      0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        1, 0, 32'h0, 2'd1);
    add("br_to20",   0, 1, 0, 32'h0,       32'h20,       0, 1, 32'h20,       1, 0, 32'h0, 2'd1);
    if (TRAP_EN) begin
      add("misalign",  0, 1, 0, 32'h0,     32'h2,        0, 1, 32'h100,      0, 1, 32'h22, 2'd3);
      add("trap_exit", 0, 0, 0, 32'h0,     32'h0,        0, 1, 32'h100,      1, 0, 32'h22, 2'd1);
      add("trap_run",  0, 0, 0, 32'h0,     32'h0,        0, 1, 32'h104,      1, 0, 32'h22, 2'd1);
      add("jalr_mis",  0, 1, 1, 32'h3,     32'h0,        0, 1, 32'h100,      0, 1, 32'h2,  2'd3);
    end else begin
      add("misalign",  0, 1, 0, 32'h0,     32'h2,        0, 1, 32'h20,       1, 0, 32'h0,  2'd1);
      add("trap_exit", 0, 0, 0, 32'h0,     32'h0,        0, 1, 32'h24,       1, 0, 32'h0,  2'd1);
      add("trap_run",  0, 0, 0, 32'h0,     32'h0,        0, 1, 32'h28,       1, 0, 32'h0,  2'd1);
      add("jalr_mis",  0, 1, 1, 32'h3,     32'h0,        0, 1, 32'h0,        1, 0, 32'h0,  2'd1);
    end
    add("rst_trap",  1, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        0, 0, 32'h0, 2'd0);
    add("reboot",    0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        1, 0, 32'h0, 2'd1);
    add("reseq4",    0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h4,        1, 0, 32'h0, 2'd1);
    add("to_wait",   0, 0, 0, 32'h0,       32'h0,        0, 0, 32'h4,        1, 0, 32'h0, 2'd2);
    add("rst_wait",  1, 0, 0, 32'h0,       32'h0,        0, 0, 32'h0,        0, 0, 32'h0, 2'd0);
    add("boot2",     0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h0,        1, 0, 32'h0, 2'd1);
    add("boot2_seq", 0, 0, 0, 32'h0,       32'h0,        0, 1, 32'h4,        1, 0, 32'h0, 2'd1);

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(posedge clk);
      #1;
      compare_one();
    end

    // Hand-written: a trap pulse lasts exactly one cycle even with a
    // stall arriving right after it, and the faulting address survives.
    mis_pc = TRAP_EN ? 32'h100 : 32'h4;
    mis_ta = TRAP_EN ? 32'h5   : 32'h0;
    drive('{name:"h_mis", rst:0, bt:1, jalr:0, rs1:0, imm:32'h1, stall:0, rdy:1,
            exp_pc:mis_pc, exp_req:!TRAP_EN, exp_trap:TRAP_EN, exp_taddr:mis_ta,
            exp_st:(TRAP_EN ? 2'd3 : 2'd1)});
    @(posedge clk); #1; compare_one();
    drive('{name:"h_stall", rst:0, bt:0, jalr:0, rs1:0, imm:0, stall:1, rdy:1,
            exp_pc:mis_pc, exp_req:1, exp_trap:0, exp_taddr:mis_ta, exp_st:2'd1});
    @(posedge clk); #1; compare_one();
    drive('{name:"h_resume", rst:0, bt:0, jalr:0, rs1:0, imm:0, stall:0, rdy:1,
            exp_pc:mis_pc + 32'd4, exp_req:1, exp_trap:0, exp_taddr:mis_ta, exp_st:2'd1});
    @(posedge clk); #1; compare_one();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage directly downstream of the branch-decision unit.
- Consumes the per-cycle branch_taken decision and computes the next PC: sequential, PC-relative branch/jal, or register-relative jalr.
- Holds the PC register and the fetch request/ready handshake with instruction memory.
- Sequences boot, stall and misaligned-target handling.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
TRAP_VECTOR, 32'h0000_0100, PC loaded on a misaligned-target trap (used only with PC_MISALIGN_TRAP_EN)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
branch_taken  input  1  from branch unit; 1 = redirect PC this cycle
is_jalr  input  1  1 = register-relative target (rs1+imm), 0 = pc+imm
rs1  input  32  jalr base operand
imm  input  32  sign-extended immediate offset
stall  input  1  core hold request (e.g. data-memory wait); freezes PC
imem_ready  input  1  instruction memory has valid data for current pc
pc  output  32  current fetch address (registered)
pc_plus4  output  32  pc+4, combinational; used as jal/jalr link value
imem_req  output  1  fetch request for pc
trap  output  1  one-cycle pulse on misaligned redirect
trap_addr  output  32  faulting target, held until next trap or reset

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high.
- rst=1 at an edge: pc=RESET_VECTOR, state=BOOT, imem_req=0, trap=0, trap_addr=0. This applies from any state and aborts any pending WAIT.
- States and transitions:
  - BOOT: imem_req=0 for exactly one cycle, then RUN.
  - RUN: imem_req=1. If imem_ready=1 and stall=0, the instruction commits and pc <= next_pc, staying in RUN. If imem_ready=0, go to WAIT with pc held. If stall=1 and imem_ready=1, stay in RUN with pc held.
  - WAIT: imem_req=1, pc held, branch_taken ignored. Go to RUN on imem_ready=1; the commit happens in the following RUN cycle.
  - TRAP (feature only): one cycle. pc already equals TRAP_VECTOR, imem_req=0, trap=1. Then go to RUN.
- next_pc:
  - branch_taken=0: pc+4.
  - branch_taken=1 and is_jalr=0: pc+imm.
  - branch_taken=1 and is_jalr=1: (rs1+imm) with bit0 cleared.
- Arithmetic: all adds are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- branch_taken is sampled only on commit edges (RUN, imem_ready=1, stall=0). Values in other cycles have no effect.
- Simultaneous stall=1 and branch_taken=1: no redirect; the decision is re-evaluated at the next commit.
- Latency: redirect is visible on pc one cycle after the commit edge. pc_plus4 follows pc combinationally.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Enabled: a committed redirect with next_pc[1:0]!=0 does the following at that edge:
  - pc <= TRAP_VECTOR
  - trap_addr <= next_pc
  - state <= TRAP, so trap=1 for one cycle
  - Sequential pc+4 never traps.
- Disabled:
  - next_pc[1:0] is forced to 2'b00.
  - trap is tied to 0 and trap_addr to 0.
  - No TRAP state exists.

Decomposition:
- Shared package cpu_pkg holds the state encoding (BOOT=2'd0, RUN=2'd1, WAIT=2'd2, TRAP=2'd3), the XLEN=32 constant and the default vector constants.
- One natural sub-module: next_pc_calc, a combinational target mux and adders, instantiated inside pc_unit.

Test Plan:
1. Reset/boot: rst=1 for 2 cycles, then 0 with imem_ready=1. Expect pc=0, imem_req=0 for one cycle, then pc sequence 0,4,8,C.
2. Branch: pc=0x20, branch_taken=1, is_jalr=0, imm=0xFFFF_FFF0. Expect next pc=0x10 and pc_plus4=0x14 in the following cycle.
3. jalr: rs1=0x1001, imm=0x4, is_jalr=1, branch_taken=1. Expect pc=0x1004 (bit0 cleared).
4. Stall/wait:
   - imem_ready=0 for 3 cycles at pc=0x40: expect pc held at 0x40, imem_req=1 throughout, then 0x44 one cycle after ready returns.
   - stall=1 with branch_taken=1: expect no redirect.
5. Wrap: pc=0xFFFF_FFFC, no branch. Expect pc=0x0000_0000.
6. Misaligned target pc+imm=0x22:
   - With PC_MISALIGN_TRAP_EN: pc=0x100, trap=1 for one cycle, trap_addr=0x22.
   - Without the macro: pc=0x20, trap=0.
   - rst asserted during TRAP: pc=RESET_VECTOR, trap=0.
